// File: rtl/rect_batch_fetcher.sv
// Streams RECT_COUNT rect descriptors of FIELDS words from bsram in batches of BATCH rects.
// Optional RECT_CHECKSUM_EN adds a running XOR of every delivered word on out_checksum.
module rect_batch_fetcher #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 16,
    parameter int BASE_ADDR  = 0,
    parameter int RECT_COUNT = 64,
    parameter int FIELDS     = 6,
    parameter int BATCH      = 16,
    localparam int RW = (BATCH > 1) ? $clog2(BATCH) : 1,
    localparam int FW = (FIELDS > 1) ? $clog2(FIELDS) : 1,
    localparam int BW = $clog2(RECT_COUNT / BATCH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  copy_start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_din,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RW-1:0]         out_rect,
    output logic [FW-1:0]         out_field,
    output logic [BW-1:0]         batch_idx,
    output logic                  batch_done,
    input  logic                  batch_ack,
    output logic                  busy,
`ifdef RECT_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] out_checksum,
`endif
    output logic                  done
);
    // state      | meaning
    // IDLE       | waiting for copy_start
    // FETCH      | issuing one read address per cycle for the current batch
    // DRAIN      | last two words of the batch still in the read pipeline
    // BATCH_WAIT | batch delivered, holding until batch_ack

    localparam int WORDS = BATCH * FIELDS;
    localparam int CW    = $clog2(WORDS + 1);
    localparam int NB    = RECT_COUNT / BATCH;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, BATCH_WAIT} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   fcnt;
    logic            rd_valid;
    logic [FW-1:0]   f_cnt;
    logic [RW-1:0]   r_cnt;
    logic            last_batch;

    assign last_batch = (batch_idx == BW'(NB - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (copy_start) state_nxt = FETCH;
            FETCH:      if (fcnt == CW'(WORDS - 1)) state_nxt = DRAIN;
            DRAIN:      if (fcnt == CW'(1)) state_nxt = BATCH_WAIT;
            BATCH_WAIT: if (batch_ack) state_nxt = last_batch ? IDLE : FETCH;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        batch_done = (state == DRAIN) || (state == BATCH_WAIT);
    end

    // Address side: fcnt counts issued addresses in FETCH, then the two drain cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
            fcnt      <= '0;
            batch_idx <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (copy_start) begin
                        mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
                        batch_idx <= '0;
                        fcnt      <= '0;
                    end
                end
                FETCH: begin
                    mem_addr <= mem_addr + ADDR_WIDTH'(1);
                    fcnt     <= (fcnt == CW'(WORDS - 1)) ? '0 : fcnt + CW'(1);
                end
                DRAIN: begin
                    fcnt <= (fcnt == CW'(1)) ? '0 : fcnt + CW'(1);
                end
                BATCH_WAIT: begin
                    if (batch_ack) begin
                        fcnt <= '0;
                        if (last_batch) done <= 1'b1;
                        else            batch_idx <= batch_idx + BW'(1);
                    end
                end
                default: fcnt <= '0;
            endcase
        end
    end

    // Data side: rd_valid marks mem_din as valid, output stage registers it one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_field <= '0;
            out_rect  <= '0;
            f_cnt     <= '0;
            r_cnt     <= '0;
        end else begin
            rd_valid  <= (state == FETCH);
            out_valid <= rd_valid;
            if (state == IDLE && copy_start) begin
                f_cnt <= '0;
                r_cnt <= '0;
            end else if (rd_valid) begin
                out_data  <= mem_din;
                out_field <= f_cnt;
                out_rect  <= r_cnt;
                if (f_cnt == FW'(FIELDS - 1)) begin
                    f_cnt <= '0;
                    r_cnt <= (r_cnt == RW'(BATCH - 1)) ? '0 : r_cnt + RW'(1);
                end else begin
                    f_cnt <= f_cnt + FW'(1);
                end
            end
        end
    end

`ifdef RECT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         csum <= '0;
        else if (state == IDLE && copy_start) csum <= '0;
        else if (rd_valid)                  csum <= csum ^ mem_din;
    end

    assign out_checksum = csum;
`endif

endmodule
